// File: rtl/time_pulse_generator.sv
// time_pulse_generator
//   Upstream timing stage for the service gates. Divides SIM_CLK into PHASES
//   phases per time pulse and twelve time pulses (T01..T12) per memory cycle,
//   and produces the phase strobes used to build register read/write/clear
//   gates. Supports monitor stop at the MCT boundary and GOJAM restart.
//
//   Optional build macro: TPG_STEP_EN adds the MSTEP single-MCT step input.
//
//   Ports:
//     SIM_CLK  in   system clock, rising edge
//     SIM_RST  in   asynchronous active-low reset
//     EN       in   phase-advance enable (low = hold everything)
//     GOJAM    in   synchronous restart to T01 ph=0, highest priority
//     MSTP     in   monitor stop, sampled at the end of T12
//     MSTEP    in   (TPG_STEP_EN only) asynchronous step request
//     TP_n     out  one-hot active-low time pulses, bit k = T(k+1)_n
//     T10_n    out  copy of TP_n[9]
//     TT_n     out  transfer strobe (ph=0), active low
//     RT_n     out  read strobe (ph=1), active low
//     WT_n     out  write strobe (ph=2), active low
//     CT_n     out  clear strobe (ph=3), active low
//     MCT      out  one-cycle marker of the first cycle of an MCT
//     STOPPED  out  high while halted by MSTP
module time_pulse_generator #(
    parameter int unsigned PHASES = 4,
    parameter int unsigned NTP    = 12
) (
    input  logic        SIM_CLK,
    input  logic        SIM_RST,
    input  logic        EN,
    input  logic        GOJAM,
    input  logic        MSTP,
`ifdef TPG_STEP_EN
    input  logic        MSTEP,
`endif
    output logic [11:0] TP_n,
    output logic        T10_n,
    output logic        TT_n,
    output logic        RT_n,
    output logic        WT_n,
    output logic        CT_n,
    output logic        MCT,
    output logic        STOPPED
);

    generate
        if (NTP != 12) begin : g_bad_ntp
            $error("time_pulse_generator: NTP must be 12");
        end
        if (PHASES < 4 || PHASES > 16) begin : g_bad_phases
            $error("time_pulse_generator: PHASES must be in 4..16");
        end
    endgenerate

    localparam int unsigned     PH_W    = $clog2(PHASES);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);

    logic [PH_W-1:0] ph, ph_nxt;
    logic [3:0]      tp, tp_nxt;
    logic            stop, stop_nxt;
    logic            mct_nxt;
    logic            step_go;

`ifdef TPG_STEP_EN
    logic mstep_s1, mstep_s2, mstep_s3;
    logic step_req;
    logic step_edge;

    assign step_edge = mstep_s2 & ~mstep_s3;
    assign step_go   = step_req | step_edge;

    // A step edge seen while stopped is remembered until an enabled cycle
    // can consume it; leaving stop by any route (incl. GOJAM) drops it.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            mstep_s1 <= 1'b0;
            mstep_s2 <= 1'b0;
            mstep_s3 <= 1'b0;
            step_req <= 1'b0;
        end else begin
            mstep_s1 <= MSTEP;
            mstep_s2 <= mstep_s1;
            mstep_s3 <= mstep_s2;
            step_req <= stop & stop_nxt & step_go;
        end
    end
`else
    assign step_go = 1'b0;
`endif

    always_comb begin
        ph_nxt   = ph;
        tp_nxt   = tp;
        stop_nxt = stop;
        mct_nxt  = MCT;
        if (GOJAM) begin
            ph_nxt   = '0;
            tp_nxt   = 4'd1;
            stop_nxt = 1'b0;
            mct_nxt  = 1'b0;
        end else if (EN) begin
            mct_nxt = 1'b0;
            if (stop) begin
                if (!MSTP || step_go) begin
                    stop_nxt = 1'b0;
                    ph_nxt   = '0;
                    tp_nxt   = 4'd1;
                    mct_nxt  = 1'b1;
                end
            end else if (ph != PH_LAST) begin
                ph_nxt = ph + PH_W'(1);
            end else begin
                ph_nxt = '0;
                if (tp == 4'd12) begin
                    // Stop is parked at T01 ph=0 so the exit needs no reload.
                    tp_nxt = 4'd1;
                    if (MSTP) begin
                        stop_nxt = 1'b1;
                    end else begin
                        mct_nxt = 1'b1;
                    end
                end else begin
                    tp_nxt = tp + 4'd1;
                end
            end
        end
    end

    // Outputs are registered decodes of the next state, so every output is
    // a flop and tracks the state it describes in the same cycle.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            ph      <= '0;
            tp      <= 4'd1;
            stop    <= 1'b0;
            TP_n    <= 12'hFFE;
            T10_n   <= 1'b1;
            TT_n    <= 1'b0;
            RT_n    <= 1'b1;
            WT_n    <= 1'b1;
            CT_n    <= 1'b1;
            MCT     <= 1'b0;
            STOPPED <= 1'b0;
        end else begin
            ph      <= ph_nxt;
            tp      <= tp_nxt;
            stop    <= stop_nxt;
            TP_n    <= stop_nxt ? '1 : ~(12'd1 << (tp_nxt - 4'd1));
            T10_n   <= stop_nxt || (tp_nxt != 4'd10);
            TT_n    <= stop_nxt || (ph_nxt != PH_W'(0));
            RT_n    <= stop_nxt || (ph_nxt != PH_W'(1));
            WT_n    <= stop_nxt || (ph_nxt != PH_W'(2));
            CT_n    <= stop_nxt || (ph_nxt != PH_W'(3));
            MCT     <= mct_nxt;
            STOPPED <= stop_nxt;
        end
    end

endmodule

// File: tb/tb_time_pulse_generator.sv
module tb_time_pulse_generator;

    localparam int PHASES = 4;
    localparam int MCT_LEN = PHASES * 12;

    logic        SIM_CLK = 1'b0;
    logic        SIM_RST = 1'b1;
    logic        EN = 1'b0;
    logic        GOJAM = 1'b0;
    logic        MSTP = 1'b0;
    logic        MSTEP = 1'b0;
    logic [11:0] TP_n;
    logic        T10_n, TT_n, RT_n, WT_n, CT_n, MCT, STOPPED;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit check_en = 1'b0;

    time_pulse_generator #(.PHASES(PHASES), .NTP(12)) dut (
        .SIM_CLK (SIM_CLK),
        .SIM_RST (SIM_RST),
        .EN      (EN),
        .GOJAM   (GOJAM),
        .MSTP    (MSTP),
`ifdef TPG_STEP_EN
        .MSTEP   (MSTEP),
`endif
        .TP_n    (TP_n),
        .T10_n   (T10_n),
        .TT_n    (TT_n),
        .RT_n    (RT_n),
        .WT_n    (WT_n),
        .CT_n    (CT_n),
        .MCT     (MCT),
        .STOPPED (STOPPED)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)",
                     name, act, exp, cyc, $time);
        end
    endtask

    // Model: position within the MCT as a single linear count 0..MCT_LEN-1.
    int m_pos = 0;
    bit m_stop = 1'b0;
    bit m_mct = 1'b0;
    bit m_pend = 1'b0;
    bit h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

    always @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            m_pos = 0; m_stop = 0; m_mct = 0; m_pend = 0;
            h1 = 0; h2 = 0; h3 = 0;
        end else begin
            bit edge_seen;
`ifdef TPG_STEP_EN
            edge_seen = h2 & ~h3;
`else
            edge_seen = 1'b0;
`endif
            h3 = h2; h2 = h1; h1 = MSTEP;
            if (GOJAM) begin
                m_pos = 0; m_stop = 0; m_mct = 0; m_pend = 0;
            end else if (EN) begin
                m_mct = 0;
                if (m_stop) begin
                    if (!MSTP || m_pend || edge_seen) begin
                        m_stop = 0; m_pos = 0; m_mct = 1; m_pend = 0;
                    end else begin
                        m_pend = m_pend | edge_seen;
                    end
                end else begin
                    m_pend = 0;
                    if (m_pos == MCT_LEN - 1) begin
                        m_pos = 0;
                        if (MSTP) m_stop = 1;
                        else m_mct = 1;
                    end else begin
                        m_pos++;
                    end
                end
            end else if (m_stop) begin
                m_pend = m_pend | edge_seen;
            end
        end
    end

    function automatic logic [18:0] model_out();
        logic [11:0] tpn;
        logic [3:0]  st;
        int          ph;
        ph = m_pos % PHASES;
        if (m_stop) begin
            tpn = '1;
            st  = 4'hF;
        end else begin
            tpn = ~(12'd1 << (m_pos / PHASES));
            st  = (ph < 4) ? ~(4'b1000 >> ph) : 4'hF;
        end
        return {tpn, tpn[9], st, m_mct, m_stop};
    endfunction

    always @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) cyc = 0;
        else cyc++;
    end

    always @(negedge SIM_CLK) begin
        if (check_en) begin
            chk("outputs", 32'({TP_n, T10_n, TT_n, RT_n, WT_n, CT_n, MCT, STOPPED}),
                32'(model_out()));
            chk("one_strobe", 32'($countones(~{TT_n, RT_n, WT_n, CT_n}) <= 1), 32'd1);
        end
    end

    // Advance to just after the edge that produces cycle c.
    task automatic goto(input int c);
        int guard;
        guard = 0;
        while (cyc < c && guard < 2000) begin
            @(posedge SIM_CLK);
            #1;
            guard++;
        end
        if (cyc != c) begin
            checks++;
            errors++;
            $display("FAIL goto: got cycle %0d expected %0d", cyc, c);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_tp"}, 32'(TP_n), 32'h0FFE);
        chk({tag, "_strb"}, 32'({TT_n, RT_n, WT_n, CT_n}), 32'b0111);
        chk({tag, "_misc"}, 32'({MCT, STOPPED, T10_n}), 32'b001);
    endtask

    task automatic do_reset();
        SIM_RST = 1'b0;
        EN = 1'b1; GOJAM = 1'b0; MSTP = 1'b0; MSTEP = 1'b0;
        #1;
        @(negedge SIM_CLK);
        SIM_RST = 1'b1;
    endtask

    initial begin
        int run_cycles;
        int mct_count;
        #1 SIM_RST = 1'b0;
        #1 check_en = 1'b1;
        check_reset_vals("reset");
        @(negedge SIM_CLK);
        EN = 1'b1;
        SIM_RST = 1'b1;

        // Free run
        goto(1);
        chk("first_edge_rt", 32'({TT_n, RT_n, WT_n, CT_n}), 32'b1011);
        goto(35); chk("t10_before", 32'(T10_n), 32'd1);
        goto(36); chk("t10_36", 32'(T10_n), 32'd0);
        goto(39); chk("t10_39", 32'(T10_n), 32'd0);
        goto(40); chk("t10_after", 32'(T10_n), 32'd1);
        goto(47); chk("mct_47", 32'(MCT), 32'd0);
        goto(48); chk("mct_48", 32'(MCT), 32'd1);
        chk("tp_48", 32'(TP_n), 32'h0FFE);
        goto(49); chk("mct_49", 32'(MCT), 32'd0);
        goto(96); chk("mct_96", 32'(MCT), 32'd1);
        goto(144); chk("mct_144", 32'(MCT), 32'd1);

        // EN gating at T05 ph=2
        do_reset();
        goto(18);
        chk("t05_wt", 32'({TP_n, WT_n}), 32'({12'hFEF, 1'b0}));
        EN = 1'b0;
        for (int c = 19; c <= 23; c++) begin
            goto(c);
            chk("en_hold_wt", 32'(WT_n), 32'd0);
        end
        EN = 1'b1;
        goto(48); chk("mct_not_48", 32'(MCT), 32'd0);
        goto(52); chk("mct_52", 32'(MCT), 32'd0);
        goto(53); chk("mct_53", 32'(MCT), 32'd1);
        EN = 1'b0;
        goto(55); chk("mct_pending", 32'(MCT), 32'd1);
        EN = 1'b1;
        goto(56); chk("mct_cleared", 32'(MCT), 32'd0);

        // Stop and exit
        do_reset();
        goto(24); MSTP = 1'b1;
        goto(47); chk("stop_47", 32'(STOPPED), 32'd0);
        goto(48);
        chk("stop_48", 32'({STOPPED, MCT}), 32'b10);
        chk("stop_tp", 32'(TP_n), 32'h0FFF);
        chk("stop_strb", 32'({TT_n, RT_n, WT_n, CT_n}), 32'hF);
        goto(51); chk("stop_held", 32'(STOPPED), 32'd1);
        MSTP = 1'b0;
        goto(52);
        MSTP = 1'b1;
        chk("exit_tp", 32'(TP_n), 32'h0FFE);
        chk("exit_misc", 32'({MCT, STOPPED, TT_n}), 32'b100);
        goto(99); chk("restop_99", 32'(STOPPED), 32'd0);
        goto(100); chk("restop_100", 32'(STOPPED), 32'd1);
        goto(101); GOJAM = 1'b1;
        goto(102);
        chk("gojam_stop_clr", 32'({STOPPED, MCT, TT_n}), 32'b000);
        chk("gojam_stop_tp", 32'(TP_n), 32'h0FFE);
        goto(104);
        chk("gojam_pinned", 32'({TP_n, TT_n}), 32'({12'hFFE, 1'b0}));
        GOJAM = 1'b0; MSTP = 1'b0;

        // GOJAM at T09 ph=3 with EN low
        goto(139);
        chk("t09_ct", 32'({TP_n, CT_n}), 32'({12'hEFF, 1'b0}));
        GOJAM = 1'b1; EN = 1'b0;
        goto(140);
        chk("gojam_tp", 32'(TP_n), 32'h0FFE);
        chk("gojam_tt_mct", 32'({TT_n, MCT}), 32'b00);
        GOJAM = 1'b0; EN = 1'b1;

        // Async reset at T11 ph=2, between edges
        goto(182);
        chk("t11_wt", 32'({TP_n, WT_n}), 32'({12'hBFF, 1'b0}));
        #2 SIM_RST = 1'b0;
        #1 check_reset_vals("async");
        @(negedge SIM_CLK);
        SIM_RST = 1'b1;
        goto(1);
        chk("post_async_rt", 32'(RT_n), 32'd0);

`ifdef TPG_STEP_EN
        // Single MCT step from stop
        do_reset();
        MSTP = 1'b1;
        goto(48); chk("step_stopped", 32'(STOPPED), 32'd1);
        goto(50); MSTEP = 1'b1;
        goto(51); MSTEP = 1'b0;
        run_cycles = 0;
        mct_count = 0;
        for (int c = 52; c <= 110; c++) begin
            goto(c);
            if (!STOPPED) run_cycles++;
            if (MCT) mct_count++;
            if (c == 70) MSTEP = 1'b1;
            if (c == 71) MSTEP = 1'b0;
        end
        chk("step_run_cycles", 32'(run_cycles), 32'd48);
        chk("step_mct_count", 32'(mct_count), 32'd1);
        chk("step_restopped", 32'(STOPPED), 32'd1);
`else
        run_cycles = 0;
        mct_count = 0;
`endif

        @(negedge SIM_CLK);
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
